// File: rtl/mr_if.sv
`default_nettype none
// ============================================================================
// Module   : mr_if
// Brief    : In-order instruction fetch stage with credit-based prefetch and
//            redirect flush. Define MR_IF_PREFETCH_EN for a 2-deep pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef XLEN
`define XLEN 32
`endif
`ifndef IMAXLEN
`define IMAXLEN 32
`endif

module mr_if #(
    parameter logic [`XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [`XLEN-1:0]    imem_req_addr,
    input  logic                imem_rsp_valid,
    input  logic [`IMAXLEN-1:0] imem_rsp_data,
    output logic [`IMAXLEN-1:0] inst,
    output logic [`XLEN-1:0]    inst_pc,
    output logic                inst_valid,
    input  logic                inst_ready,
    input  logic                jmp_done,
    input  logic [`XLEN-1:0]    jmp_target
);

`ifdef MR_IF_PREFETCH_EN
    localparam int c_DEPTH = 2;
`else
    localparam int c_DEPTH = 1;
`endif
    localparam int c_CNT_W = 2;

    logic [`XLEN-1:0]    r_fetch_pc;
    logic [c_CNT_W-1:0]  r_outstanding;
    logic [c_CNT_W-1:0]  r_drop_cnt;
    logic [c_CNT_W-1:0]  r_fifo_count;

    logic [`XLEN-1:0]    r_pend_pc [0:c_DEPTH-1];
    logic                r_pend_wr;
    logic                r_pend_rd;

    logic [`IMAXLEN-1:0] r_fifo_inst [0:c_DEPTH-1];
    logic [`XLEN-1:0]    r_fifo_pc   [0:c_DEPTH-1];
    logic                r_fifo_wr;
    logic                r_fifo_rd;

    logic                w_req_acc;
    logic                w_pop;
    logic                w_push;
    logic [2:0]          w_used;
    logic [c_CNT_W-1:0]  w_out_next;
    logic [`XLEN-1:0]    w_jmp_aligned;

    function automatic logic f_next(input logic p);
        return (c_DEPTH == 1) ? 1'b0 : ~p;
    endfunction

    // Credit counts the FIFO after this cycle's pop so a consumed slot can be
    // refilled immediately; the sum never rises without an acceptance, which
    // keeps a pending request asserted until the memory takes it.
    assign w_pop          = inst_valid && inst_ready;
    assign w_used         = {1'b0, r_outstanding} + {1'b0, r_fifo_count} - {2'b00, w_pop};
    assign imem_req_valid = rst_n && (w_used < 3'(c_DEPTH));
    assign imem_req_addr  = r_fetch_pc;
    assign w_req_acc      = imem_req_valid && imem_req_ready;

    assign w_out_next     = r_outstanding + c_CNT_W'(w_req_acc) - c_CNT_W'(imem_rsp_valid);
    assign w_push         = imem_rsp_valid && (r_drop_cnt == '0) && !jmp_done;
    assign w_jmp_aligned  = jmp_target & ~`XLEN'(3);

    assign inst_valid     = (r_fifo_count != '0);
    assign inst           = r_fifo_inst[r_fifo_rd];
    assign inst_pc        = r_fifo_pc[r_fifo_rd];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_fifo_count  <= '0;
            r_pend_wr     <= 1'b0;
            r_pend_rd     <= 1'b0;
            r_fifo_wr     <= 1'b0;
            r_fifo_rd     <= 1'b0;
            for (int i = 0; i < c_DEPTH; i++) begin
                r_pend_pc[i]   <= '0;
                r_fifo_inst[i] <= '0;
                r_fifo_pc[i]   <= '0;
            end
        end else begin
            if (jmp_done) begin
                r_fetch_pc <= w_jmp_aligned;
            end else if (w_req_acc) begin
                r_fetch_pc <= r_fetch_pc + `XLEN'(4);
            end

            if (w_req_acc) begin
                r_pend_pc[r_pend_wr] <= r_fetch_pc;
                r_pend_wr            <= f_next(r_pend_wr);
            end
            if (imem_rsp_valid) begin
                r_pend_rd <= f_next(r_pend_rd);
            end
            r_outstanding <= w_out_next;

            // Every request still in flight after a redirect belongs to the
            // old path, including one accepted in the redirect cycle.
            if (jmp_done) begin
                r_drop_cnt <= w_out_next;
            end else if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end

            if (jmp_done) begin
                r_fifo_count <= '0;
                r_fifo_wr    <= 1'b0;
                r_fifo_rd    <= 1'b0;
            end else begin
                if (w_push) begin
                    r_fifo_inst[r_fifo_wr] <= imem_rsp_data;
                    r_fifo_pc[r_fifo_wr]   <= r_pend_pc[r_pend_rd];
                    r_fifo_wr              <= f_next(r_fifo_wr);
                end
                if (w_pop) begin
                    r_fifo_rd <= f_next(r_fifo_rd);
                end
                r_fifo_count <= r_fifo_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            end
        end
    end

`ifndef SYNTHESIS
    a_rsp_without_req: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (r_outstanding != '0));
    a_fifo_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (w_push && !w_pop) |-> (r_fifo_count != c_CNT_W'(c_DEPTH)));
    a_drop_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        r_drop_cnt <= r_outstanding);
`endif

endmodule

`default_nettype wire

// File: tb/tb_mr_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_mr_if
// Brief    : Self-checking bench for mr_if: random memory/decode timing and
//            redirects against a PC-stream reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mr_if;

`ifdef MR_IF_PREFETCH_EN
    localparam int c_DEPTH = 2;
`else
    localparam int c_DEPTH = 1;
`endif
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        jmp_done;
    logic [31:0] jmp_target;

    mr_if #(.RESET_PC(c_RESET_PC)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .jmp_done       (jmp_done),
        .jmp_target     (jmp_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    endfunction

    // stimulus knobs
    int          lat_min, lat_max, rdy_pct, irdy_pct, jmp_pct;
    logic        rst_drive, force_jmp;
    logic [31:0] force_tgt;

    // memory model and expected streams
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          cyc = 0;
    logic [31:0] exp_pc, exp_fetch;
    int          n_hs = 0, n_acc = 0;

    // per-cycle samples and history
    logic        s_req_valid, s_inst_valid, s_hs, s_acc;
    logic [31:0] s_addr, s_inst_pc;
    logic        p_rst = 1'b0, p_inst_hold = 1'b0, p_req_hold = 1'b0;
    logic [31:0] p_pc, p_inst, p_addr;

    task automatic step();
        rst_n          = rst_drive;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        inst_ready     = ($urandom_range(99) < irdy_pct);
        jmp_done       = force_jmp || (jmp_pct != 0 && $urandom_range(99) < jmp_pct);
        jmp_target     = force_jmp ? force_tgt : 32'($urandom_range(0, 1023));
        if (rst_drive && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        s_req_valid  = imem_req_valid;
        s_addr       = imem_req_addr;
        s_inst_valid = inst_valid;
        s_inst_pc    = inst_pc;
        s_hs         = 1'b0;
        s_acc        = 1'b0;

        if (p_inst_hold) begin
            check_eq("inst_hold_valid", inst_valid, 1);
            check_eq("inst_hold_pc", inst_pc, p_pc);
            check_eq("inst_hold_data", inst, p_inst);
        end
        if (p_req_hold && rst_drive) begin
            check_eq("req_hold_valid", imem_req_valid, 1);
            check_eq("req_hold_addr", imem_req_addr, p_addr);
        end

        if (!rst_drive) begin
            check_eq("rst_req_valid", imem_req_valid, 0);
            if (p_rst) begin
                check_eq("rst_inst_valid", inst_valid, 0);
                check_eq("rst_inst", inst, 0);
                check_eq("rst_inst_pc", inst_pc, 0);
            end
            mq_addr.delete();
            mq_due.delete();
            exp_pc      = c_RESET_PC;
            exp_fetch   = c_RESET_PC;
            p_inst_hold = 1'b0;
            p_req_hold  = 1'b0;
        end else begin
            s_hs  = inst_valid && inst_ready;
            s_acc = imem_req_valid && imem_req_ready;
            if (s_hs) begin
                check_eq("inst_pc", inst_pc, exp_pc);
                check_eq("inst_data", inst, mem_word(exp_pc));
                exp_pc += 4;
                n_hs++;
            end
            if (s_acc) begin
                check_eq("req_addr", imem_req_addr, exp_fetch);
                exp_fetch += 4;
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(cyc + $urandom_range(lat_min, lat_max));
                check_eq("credit_limit", 32'(mq_addr.size() <= c_DEPTH), 1);
                n_acc++;
            end
            if (jmp_done) begin
                exp_pc    = {jmp_target[31:2], 2'b00};
                exp_fetch = {jmp_target[31:2], 2'b00};
            end
            p_inst_hold = inst_valid && !inst_ready && !jmp_done;
            p_req_hold  = imem_req_valid && !imem_req_ready && !jmp_done;
            p_pc        = inst_pc;
            p_inst      = inst;
            p_addr      = imem_req_addr;
        end
        p_rst = !rst_drive;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_drive = 1'b0;
        repeat (n) step();
        rst_drive = 1'b1;
    endtask

    task automatic wait_hs_pc(input string tag, input logic [31:0] exp);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (s_hs) begin
                seen = 1'b1;
                check_eq(tag, s_inst_pc, exp);
            end
        end
        check_eq({tag, "_timeout"}, 32'(seen), 1);
    endtask

    initial begin
        int first, hs0, acc0;
        logic ok;
        rst_drive = 1'b0; force_jmp = 1'b0; force_tgt = '0;
        lat_min = 1; lat_max = 1; rdy_pct = 100; irdy_pct = 100; jmp_pct = 0;
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        inst_ready = 1'b0; jmp_done = 1'b0; jmp_target = '0;
        @(posedge clk);
        #1;

        // reset values, then first fetch and full-rate streaming
        do_reset(3);
        first = -1;
        hs0 = n_hs;
        for (int i = 0; i < 20; i++) begin
            step();
            if (s_inst_valid && first < 0) first = i;
        end
        check_eq("first_valid_cycle", 32'(first), 2);
        check_eq("stream_rate", 32'(n_hs - hs0), (c_DEPTH == 2) ? 32'd18 : 32'd9);

        // decode stalled: requests bounded by credit, head holds
        do_reset(2);
        irdy_pct = 0;
        acc0 = n_acc;
        repeat (10) step();
        check_eq("stall_req_count", 32'(n_acc - acc0), c_DEPTH);
        check_eq("stall_inst_valid", s_inst_valid, 1);
        check_eq("stall_inst_pc", s_inst_pc, 32'h0);
        irdy_pct = 100;
        repeat (6) step();

        // redirect with the pipe full of in-flight requests
        do_reset(2);
        lat_min = 4; lat_max = 4;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = (mq_addr.size() == c_DEPTH);
        end
        check_eq("jmp_setup", 32'(ok), 1);
        force_jmp = 1'b1; force_tgt = 32'h100;
        step();
        force_jmp = 1'b0;
        step();
        check_eq("flush_empty", s_inst_valid, 0);
        check_eq("redirect_addr", s_addr, 32'h100);
        wait_hs_pc("post_jmp_pc", 32'h100);

        // unaligned target
        lat_min = 1; lat_max = 1;
        repeat (5) step();
        force_jmp = 1'b1; force_tgt = 32'h103;
        step();
        force_jmp = 1'b0;
        step();
        check_eq("unaligned_redirect_addr", s_addr, 32'h100);
        wait_hs_pc("unaligned_jmp_pc", 32'h100);

        // random traffic with redirects
        lat_min = 1; lat_max = 4; rdy_pct = 70; irdy_pct = 70; jmp_pct = 3;
        hs0 = n_hs;
        repeat (1000) step();
        check_eq("random_progress", 32'(n_hs - hs0 > 50), 1);

        // one-cycle reset mid-stream
        rst_drive = 1'b0;
        step();
        check_eq("midrst_req_valid", s_req_valid, 0);
        rst_drive = 1'b1;
        step();
        check_eq("midrst_inst_valid", s_inst_valid, 0);
        check_eq("midrst_req_valid_after", s_req_valid, 1);
        check_eq("midrst_req_addr", s_addr, c_RESET_PC);
        repeat (200) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
